// File: rtl/floating_point_result_buffer.sv
// Result buffer placed after floating_point_multiplier.
// It holds products and their exception flags in a small FIFO with a valid/ready
// handshake. It also keeps sticky status flags and saturating per-flag event counters.
module floating_point_result_buffer #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int DEPTH          = 4,
    parameter int COUNT_WIDTH    = 16,
    localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
    localparam int PTR_WIDTH       = $clog2(DEPTH),
    localparam int LEVEL_WIDTH     = PTR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FLOAT_BIT_WIDTH-1:0] in_result,
    input  logic                       in_underflow_flag,
    input  logic                       in_overflow_flag,
    input  logic                       in_invalid_operation_flag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLOAT_BIT_WIDTH-1:0] out_result,
    output logic [2:0]                 out_flags,
    input  logic                       flush,
    input  logic                       clear_sticky,
    output logic [2:0]                 sticky_flags,
    output logic [COUNT_WIDTH-1:0]     underflow_count,
    output logic [COUNT_WIDTH-1:0]     overflow_count,
    output logic [COUNT_WIDTH-1:0]     invalid_count,
    output logic [LEVEL_WIDTH-1:0]     level
);

    logic [FLOAT_BIT_WIDTH-1:0] data_mem [DEPTH];
    logic [2:0]                 flag_mem [DEPTH];
    logic [PTR_WIDTH-1:0]       wr_ptr;
    logic [PTR_WIDTH-1:0]       rd_ptr;
    logic [2:0]                 in_flags;
    logic                       push;
    logic                       pop;

    assign in_flags = {in_invalid_operation_flag, in_overflow_flag, in_underflow_flag};

    // in_ready depends only on the registered level. Because of this, a full buffer
    // refuses a push even in a cycle where the consumer pops.
    assign in_ready  = (level < LEVEL_WIDTH'(DEPTH));
    assign out_valid = (level != '0);

    // A flush discards the cycle's traffic. A push made during a flush is not
    // accepted, so it is not counted either.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Head entry. It is forced to zero while the buffer is empty, so the outputs
    // show zero after reset even though the storage itself holds no reset value.
    assign out_result = out_valid ? data_mem[rd_ptr] : '0;
    assign out_flags  = out_valid ? flag_mem[rd_ptr] : '0;

    // Occupancy and pointer bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every block sees the pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({push, pop})
                2'b10:   level <= level + LEVEL_WIDTH'(1);
                2'b01:   level <= level - LEVEL_WIDTH'(1);
                default: level <= level;
            endcase
        end
    end

    // Entry storage. Words are written only on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset. The valid region is defined by level and the pointers, and out_* is gated by out_valid.
        if (push) begin
            data_mem[wr_ptr] <= in_result;
            flag_mem[wr_ptr] <= in_flags;
        end
    end

    // Sticky flags. A flagged push in the same cycle overrides clear_sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (clear_sticky ? 3'b000 : sticky_flags) | (push ? in_flags : 3'b000);
        end
    end

    // Saturating per-flag event counters. Only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_count <= '0;
            overflow_count  <= '0;
            invalid_count   <= '0;
        end else begin
            if (push && in_flags[0] && (underflow_count != '1))
                underflow_count <= underflow_count + COUNT_WIDTH'(1);
            if (push && in_flags[1] && (overflow_count != '1))
                overflow_count <= overflow_count + COUNT_WIDTH'(1);
            if (push && in_flags[2] && (invalid_count != '1))
                invalid_count <= invalid_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_floating_point_result_buffer.sv
// Self-checking bench for floating_point_result_buffer.
// It runs directed scenarios and then randomized traffic. Each result is compared
// against a queue-based reference model after every clock edge.
module tb_floating_point_result_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic [2:0]  in_flags;
    logic        out_ready;
    logic        flush;
    logic        clear_sticky;

    // Outputs of the default-parameter instance.
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [2:0]  out_flags, sticky_flags;
    logic [15:0] underflow_count, overflow_count, invalid_count;
    logic [2:0]  level;

    // Outputs of the COUNT_WIDTH=2 instance. It shares the same inputs.
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_result;
    logic [2:0]  s_out_flags, s_sticky_flags;
    logic [1:0]  s_underflow_count, s_overflow_count, s_invalid_count;
    logic [2:0]  s_level;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    entry_t model_q[$];
    logic [2:0] model_sticky;
    int model_cnt [3];

    always #5 clk = ~clk;

    floating_point_result_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_underflow_flag(in_flags[0]),
        .in_overflow_flag(in_flags[1]), .in_invalid_operation_flag(in_flags[2]),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .flush(flush), .clear_sticky(clear_sticky),
        .sticky_flags(sticky_flags), .underflow_count(underflow_count),
        .overflow_count(overflow_count), .invalid_count(invalid_count), .level(level)
    );

    floating_point_result_buffer #(.COUNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_underflow_flag(in_flags[0]),
        .in_overflow_flag(in_flags[1]), .in_invalid_operation_flag(in_flags[2]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_flags(s_out_flags), .flush(flush), .clear_sticky(clear_sticky),
        .sticky_flags(s_sticky_flags), .underflow_count(s_underflow_count),
        .overflow_count(s_overflow_count), .invalid_count(s_invalid_count), .level(s_level)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int sat(input int value, input int max_value);
        return (value > max_value) ? max_value : value;
    endfunction

    // Advance one clock. The model applies the rules at the edge using the held
    // inputs. Outputs are then compared 1 time unit after the edge.
    task automatic cycle();
        bit do_push, do_pop;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_sticky = 3'b000;
            for (int k = 0; k < 3; k++) model_cnt[k] = 0;
        end else begin
            do_push = in_valid && (model_q.size() < DEPTH) && !flush;
            do_pop  = (model_q.size() != 0) && out_ready && !flush;
            if (flush) model_q.delete();
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{data: in_result, flags: in_flags});
            if (clear_sticky) model_sticky = 3'b000;
            if (do_push) begin
                model_sticky |= in_flags;
                for (int k = 0; k < 3; k++) if (in_flags[k]) model_cnt[k]++;
            end
        end
        #1;
        check("in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("out_result", out_result, (model_q.size() != 0) ? model_q[0].data : 32'h0);
        check("out_flags", 32'(out_flags), (model_q.size() != 0) ? 32'(model_q[0].flags) : 32'h0);
        check("level", 32'(level), 32'(model_q.size()));
        check("sticky", 32'(sticky_flags), 32'(model_sticky));
        check("underflow_count", 32'(underflow_count), 32'(sat(model_cnt[0], 65535)));
        check("overflow_count",  32'(overflow_count),  32'(sat(model_cnt[1], 65535)));
        check("invalid_count",   32'(invalid_count),   32'(sat(model_cnt[2], 65535)));
        check("small_underflow_count", 32'(s_underflow_count), 32'(sat(model_cnt[0], 3)));
        check("small_overflow_count",  32'(s_overflow_count),  32'(sat(model_cnt[1], 3)));
        check("small_invalid_count",   32'(s_invalid_count),   32'(sat(model_cnt[2], 3)));
        check("small_level", 32'(s_level), 32'(model_q.size()));
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] f, input logic ordy);
        in_valid  = v;
        in_result = d;
        in_flags  = f;
        out_ready = ordy;
        cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0;
        out_ready = 1'b0; flush = 1'b0; clear_sticky = 1'b0;
        model_sticky = 3'b000;
        for (int k = 0; k < 3; k++) model_cnt[k] = 0;
        #2;
        cycle();
        cycle();
        rst = 1'b0;

        // 1. Single push with no wait: visible in the next cycle, then drained.
        drive(1'b1, 32'h41400000, 3'b000, 1'b1);
        check("t1_head", out_result, 32'h41400000);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t1_level", 32'(level), 32'd0);

        // 2. Fill to full, then attempt a 5th push without and with a pop.
        drive(1'b1, 32'h3F800000, 3'b000, 1'b0);
        drive(1'b1, 32'h40000000, 3'b000, 1'b0);
        drive(1'b1, 32'h40400000, 3'b000, 1'b0);
        drive(1'b1, 32'h40800000, 3'b000, 1'b0);
        check("t2_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h40A00000, 3'b000, 1'b0);
        drive(1'b1, 32'h40A00000, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 3'b000, 1'b1);

        // 3. Underflow sets sticky bit 0. Clearing sticky during an overflow push leaves 010.
        drive(1'b1, 32'h00000000, 3'b001, 1'b1);
        check("t3_sticky_uf", 32'(sticky_flags), 32'h1);
        clear_sticky = 1'b1;
        drive(1'b1, 32'h7F800000, 3'b010, 1'b1);
        clear_sticky = 1'b0;
        check("t3_sticky_set_wins", 32'(sticky_flags), 32'h2);

        // 4. Five invalid pushes: the narrow counter saturates at 3.
        clear_sticky = 1'b1;
        drive(1'b1, 32'hFFC00000, 3'b100, 1'b1);
        clear_sticky = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hFFC00000, 3'b100, 1'b1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t4_small_invalid_sat", 32'(s_invalid_count), 32'd3);
        check("t4_sticky", 32'(sticky_flags), 32'h4);

        // 5. At level 2, simultaneous push and pop, then flush with a dropped push.
        drive(1'b1, 32'h11111111, 3'b000, 1'b0);
        drive(1'b1, 32'h22222222, 3'b000, 1'b0);
        drive(1'b1, 32'h33333333, 3'b001, 1'b1);
        drive(1'b1, 32'h44444444, 3'b010, 1'b1);
        check("t5_level_steady", 32'(level), 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'h55555555, 3'b111, 1'b1);
        flush = 1'b0;
        check("t5_flush_empty", 32'(out_valid), 32'd0);

        // 6. Reset applied while holding entries and all sticky bits.
        drive(1'b1, 32'hAAAA0001, 3'b111, 1'b0);
        drive(1'b1, 32'hAAAA0002, 3'b000, 1'b0);
        drive(1'b1, 32'hAAAA0003, 3'b000, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        rst = 1'b0;
        check("t6_reset_result", out_result, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 29) == 0);
            clear_sticky = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 3) != 0, $urandom,
                  3'($urandom_range(0, 7)) & ($urandom_range(0, 1) != 0 ? 3'b111 : 3'b000),
                  $urandom_range(0, 2) != 0);
        end
        rst = 1'b0; flush = 1'b0; clear_sticky = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
